// File: rtl/match_frame_scheduler.sv
// Per-frame control sequencer for the keypoint matcher: frames the keypoint stream, gates the
// matcher's keypoint flag, strobes the matcher end after a settle delay and reports frame totals.
`timescale 1ns/1ps
module match_frame_scheduler #(
  parameter logic [11:0] MAX_KEYS       = 12'd500,
  parameter logic [7:0]  SCORE_MIN      = 8'd0,
  parameter logic [7:0]  END_DELAY      = 8'd4,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic        i_frame_end,
  input  logic        i_kp_valid,
  input  logic [7:0]  i_kp_score,
  input  logic        i_match_valid,
  input  logic        i_match_end,
  output logic        o_match_flag,
  output logic        o_match_start,
  output logic        o_match_end,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_timeout,
  output logic        o_overrun,
  output logic [11:0] o_kp_count,
  output logic [11:0] o_drop_count,
  output logic [11:0] o_match_count
);

  typedef enum logic [2:0] {StIdle, StCollect, StFlush, StWaitMatch, StDone} state_e;

  state_e      state_q, state_d;
  logic [11:0] kp_cnt_q, kp_cnt_d;
  logic [11:0] drop_cnt_q, drop_cnt_d;
  logic [11:0] match_cnt_q, match_cnt_d;
  logic [7:0]  delay_q, delay_d;
  logic [19:0] timer_q, timer_d;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        overrun_q, overrun_d;
  logic [11:0] sum_kp_q, sum_kp_d;
  logic [11:0] sum_drop_q, sum_drop_d;
  logic [11:0] sum_match_q, sum_match_d;

  logic [8:0]  score_diff;
  logic        score_ok;
  logic        flag;
  logic        match_window;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Sign of the widened difference avoids a constant compare when SCORE_MIN is zero.
  assign score_diff   = {1'b0, i_kp_score} - {1'b0, SCORE_MIN};
  assign score_ok     = ~score_diff[8];
  assign flag         = i_kp_valid & (state_q == StCollect) & score_ok & (kp_cnt_q < MAX_KEYS);
  assign match_window = (state_q == StCollect) || (state_q == StFlush) ||
                        (state_q == StWaitMatch);

  always_comb begin
    state_d     = state_q;
    kp_cnt_d    = kp_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    match_cnt_d = match_cnt_q;
    delay_d     = delay_q;
    timer_d     = timer_q;
    start_d     = 1'b0;
    end_d       = 1'b0;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    overrun_d   = i_frame_start && (state_q != StIdle);
    sum_kp_d    = sum_kp_q;
    sum_drop_d  = sum_drop_q;
    sum_match_d = sum_match_q;

    if ((state_q == StCollect) && i_kp_valid) begin
      if (flag) kp_cnt_d = sat_inc(kp_cnt_q);
      else      drop_cnt_d = sat_inc(drop_cnt_q);
    end
    if (match_window && i_match_valid) match_cnt_d = sat_inc(match_cnt_q);

    unique case (state_q)
      StIdle: begin
        if (i_frame_start) begin
          start_d     = 1'b1;
          kp_cnt_d    = '0;
          drop_cnt_d  = '0;
          match_cnt_d = '0;
          if (i_frame_end) begin
            state_d = StFlush;
            delay_d = '0;
            end_d   = (END_DELAY == 8'd0);
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (i_frame_end) begin
          state_d = StFlush;
          delay_d = '0;
          end_d   = (END_DELAY == 8'd0);
        end
      end
      StFlush: begin
        // The end strobe lands on the last FLUSH cycle.
        if (delay_q == END_DELAY) begin
          state_d = StWaitMatch;
          timer_d = '0;
        end else begin
          delay_d = delay_q + 8'd1;
          end_d   = ((delay_q + 8'd1) == END_DELAY);
        end
      end
      StWaitMatch: begin
        if (i_match_end || ((timer_q + 20'd1) >= TIMEOUT_CYCLES)) begin
          state_d     = StDone;
          done_d      = 1'b1;
          timeout_d   = ~i_match_end;
          sum_kp_d    = kp_cnt_d;
          sum_drop_d  = drop_cnt_d;
          sum_match_d = match_cnt_d;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      kp_cnt_q    <= '0;
      drop_cnt_q  <= '0;
      match_cnt_q <= '0;
      delay_q     <= '0;
      timer_q     <= '0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      sum_kp_q    <= '0;
      sum_drop_q  <= '0;
      sum_match_q <= '0;
    end else begin
      state_q     <= state_d;
      kp_cnt_q    <= kp_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      match_cnt_q <= match_cnt_d;
      delay_q     <= delay_d;
      timer_q     <= timer_d;
      start_q     <= start_d;
      end_q       <= end_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      sum_kp_q    <= sum_kp_d;
      sum_drop_q  <= sum_drop_d;
      sum_match_q <= sum_match_d;
    end
  end

  assign o_match_flag  = flag;
  assign o_match_start = start_q;
  assign o_match_end   = end_q;
  assign o_busy        = (state_q != StIdle);
  assign o_frame_done  = done_q;
  assign o_timeout     = timeout_q;
  assign o_overrun     = overrun_q;
  assign o_kp_count    = sum_kp_q;
  assign o_drop_count  = sum_drop_q;
  assign o_match_count = sum_match_q;

endmodule

// File: tb/tb_match_frame_scheduler.sv
// Scoreboard bench for match_frame_scheduler: two instances share stimulus, one with a small
// key cap and one with the 4095 cap for saturation; expectations come from frame-level rules.
`timescale 1ns/1ps
module tb_match_frame_scheduler;

  localparam int MaxA     = 4;
  localparam int MaxS     = 4095;
  localparam int ScoreMin = 10;
  localparam int EndDelay = 2;
  localparam int Timeout  = 10;

  logic clk = 1'b0;
  logic rst, fs, fe, kv, mv, me;
  logic [7:0] sc;

  logic flag_a, mstart_a, mend_a, busy_a, done_a, to_a, ovr_a;
  logic [11:0] kp_a, drop_a, mt_a;
  logic flag_s, mstart_s, mend_s, busy_s, done_s, to_s, ovr_s;
  logic [11:0] kp_s, drop_s, mt_s;

  match_frame_scheduler #(
    .MAX_KEYS(12'd4), .SCORE_MIN(8'd10), .END_DELAY(8'd2), .TIMEOUT_CYCLES(20'd10)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_frame_end(fe), .i_kp_valid(kv),
    .i_kp_score(sc), .i_match_valid(mv), .i_match_end(me), .o_match_flag(flag_a),
    .o_match_start(mstart_a), .o_match_end(mend_a), .o_busy(busy_a), .o_frame_done(done_a),
    .o_timeout(to_a), .o_overrun(ovr_a), .o_kp_count(kp_a), .o_drop_count(drop_a),
    .o_match_count(mt_a)
  );

  match_frame_scheduler #(
    .MAX_KEYS(12'd4095), .SCORE_MIN(8'd10), .END_DELAY(8'd2), .TIMEOUT_CYCLES(20'd10)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_frame_end(fe), .i_kp_valid(kv),
    .i_kp_score(sc), .i_match_valid(mv), .i_match_end(me), .o_match_flag(flag_s),
    .o_match_start(mstart_s), .o_match_end(mend_s), .o_busy(busy_s), .o_frame_done(done_s),
    .o_timeout(to_s), .o_overrun(ovr_s), .o_kp_count(kp_s), .o_drop_count(drop_s),
    .o_match_count(mt_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kp;
    int drop;
    int mt;
    int to;
    int cyc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_s[$];
  int   start_q[$];
  int   end_q[$];
  int   ovr_q[$];
  int   score_plan[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 4095) ? 4095 : x;
  endfunction

  // Drive one cycle of inputs, check the combinational flags, then advance past the edge.
  task automatic step(input int fs_v, input int fe_v, input int kv_v, input int sc_v,
                      input int mv_v, input int me_v, input int exp_fa, input int exp_fs);
    fs = fs_v[0];
    fe = fe_v[0];
    kv = kv_v[0];
    sc = sc_v[7:0];
    mv = mv_v[0];
    me = me_v[0];
    #1;
    chk("flag_a", flag_a, exp_fa);
    chk("flag_s", flag_s, exp_fs);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flag"}, flag_a, 0);
    chk({tag, "_start"}, mstart_a, 0);
    chk({tag, "_end"}, mend_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_timeout"}, to_a, 0);
    chk({tag, "_overrun"}, ovr_a, 0);
    chk({tag, "_kp"}, kp_a, 0);
    chk({tag, "_drop"}, drop_a, 0);
    chk({tag, "_match"}, mt_a, 0);
    chk({tag, "_busy_s"}, busy_s, 0);
    chk({tag, "_kp_s"}, kp_s, 0);
  endtask

  task automatic run_frame(input int nkeys, input int use_to, input int ovr, input int dense,
                           input int fixed_sc);
    int elig, nval, mt, sent, e, s, kv_v, mv_v, fs_v, last, ovr_sent;
    exp_t x;
    elig = 0; nval = 0; mt = 0; sent = 0; ovr_sent = 0;
    chk("idle_before_start", busy_a, 0);
    start_q.push_back(cyc + 1);
    e = cyc;
    step(1, (nkeys == 0) ? 1 : 0, 0, $urandom_range(0, 255), $urandom_range(0, 1), 0, 0, 0);
    chk("busy_after_start", busy_a, 1);
    while (sent < nkeys) begin
      kv_v = (dense != 0 || $urandom_range(0, 2) != 0) ? 1 : 0;
      if (fixed_sc >= 0) s = fixed_sc;
      else if (kv_v != 0 && score_plan.size() > 0) s = score_plan.pop_front();
      else s = $urandom_range(0, 255);
      mv_v = $urandom_range(0, 1);
      fs_v = (ovr != 0 && ovr_sent == 0) ? 1 : 0;
      if (fs_v != 0) begin
        ovr_q.push_back(cyc + 1);
        ovr_sent = 1;
      end
      last = (kv_v != 0 && sent == nkeys - 1) ? 1 : 0;
      e = cyc;
      mt += mv_v;
      step(fs_v, last, kv_v, s, mv_v, 0,
           (kv_v != 0 && s >= ScoreMin && elig < MaxA) ? 1 : 0,
           (kv_v != 0 && s >= ScoreMin && elig < MaxS) ? 1 : 0);
      if (kv_v != 0) begin
        nval++;
        sent++;
        if (s >= ScoreMin) elig++;
      end
    end
    end_q.push_back(e + 1 + EndDelay);
    // Settle window: keypoints and matcher end here must be ignored.
    for (int i = 0; i <= EndDelay; i++) begin
      mv_v = $urandom_range(0, 1);
      mt += mv_v;
      step(0, 0, $urandom_range(0, 1), $urandom_range(0, 255), mv_v,
           (i == 0) ? $urandom_range(0, 1) : 0, 0, 0);
    end
    if (use_to == 0) begin
      repeat ($urandom_range(0, 4)) begin
        mv_v = $urandom_range(0, 1);
        mt += mv_v;
        step(0, 0, 0, 0, mv_v, 0, 0, 0);
      end
      mv_v = $urandom_range(0, 1);
      mt += mv_v;
      step(0, 0, 0, 0, mv_v, 1, 0, 0);
    end else begin
      repeat (Timeout) begin
        mv_v = $urandom_range(0, 1);
        mt += mv_v;
        step(0, 0, 0, 0, mv_v, 0, 0, 0);
      end
    end
    x.kp   = (elig < MaxA) ? elig : MaxA;
    x.drop = sat(nval - x.kp);
    x.mt   = sat(mt);
    x.to   = use_to;
    x.cyc  = cyc;
    sb_a.push_back(x);
    x.kp   = (elig < MaxS) ? elig : MaxS;
    x.drop = sat(nval - x.kp);
    sb_s.push_back(x);
    step(0, 0, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1), 0, 0, 0);
  endtask

  task automatic reset_mid_flush();
    start_q.push_back(cyc + 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 20, 1, 0, 1, 1);
    step(0, 0, 1, 30, 0, 0, 1, 1);
    end_q.push_back(cyc + 1 + EndDelay);
    step(0, 1, 1, 40, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    sb_a.delete();
    sb_s.delete();
    start_q.delete();
    end_q.delete();
    ovr_q.delete();
    #1;
    check_zero("after_reset");
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (mstart_a === 1'b1) begin
      if (start_q.size() == 0) chk("match_start_unexpected", 1, 0);
      else chk("match_start_cycle", cyc, start_q.pop_front());
    end
    if (mend_a === 1'b1) begin
      if (end_q.size() == 0) chk("match_end_unexpected", 1, 0);
      else chk("match_end_cycle", cyc, end_q.pop_front());
    end
    if (ovr_a === 1'b1) begin
      if (ovr_q.size() == 0) chk("overrun_unexpected", 1, 0);
      else chk("overrun_cycle", cyc, ovr_q.pop_front());
    end
    if (to_a === 1'b1 && done_a !== 1'b1) chk("timeout_without_done", 1, 0);
    if (done_a === 1'b1) begin
      if (sb_a.size() == 0) chk("frame_done_unexpected", 1, 0);
      else begin
        x = sb_a.pop_front();
        chk("done_cycle", cyc, x.cyc);
        chk("kp_count", kp_a, x.kp);
        chk("drop_count", drop_a, x.drop);
        chk("match_count", mt_a, x.mt);
        chk("timeout_flag", to_a, x.to);
      end
    end
    if (done_s === 1'b1) begin
      if (sb_s.size() == 0) chk("frame_done_s_unexpected", 1, 0);
      else begin
        x = sb_s.pop_front();
        chk("kp_count_s", kp_s, x.kp);
        chk("drop_count_s", drop_s, x.drop);
        chk("match_count_s", mt_s, x.mt);
        chk("timeout_flag_s", to_s, x.to);
      end
    end
    if (start_q.size() > 0 && start_q[0] < cyc) chk("match_start_missing", cyc, start_q.pop_front());
    if (end_q.size() > 0 && end_q[0] < cyc) chk("match_end_missing", cyc, end_q.pop_front());
    if (ovr_q.size() > 0 && ovr_q[0] < cyc) chk("overrun_missing", cyc, ovr_q.pop_front());
    if (sb_a.size() > 0 && sb_a[0].cyc < cyc) begin
      x = sb_a.pop_front();
      chk("frame_done_missing", cyc, x.cyc);
    end
    if (sb_s.size() > 0 && sb_s[0].cyc < cyc) begin
      x = sb_s.pop_front();
      chk("frame_done_s_missing", cyc, x.cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fs = 1'b0; fe = 1'b0; kv = 1'b0; sc = 8'd0; mv = 1'b0; me = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0);

    run_frame(6, 0, 0, 1, 20);
    score_plan.push_back(9);
    score_plan.push_back(10);
    score_plan.push_back(255);
    run_frame(3, 0, 0, 1, -1);
    run_frame(5, 1, 0, 0, -1);
    run_frame(5, 0, 1, 0, -1);
    run_frame(0, 0, 0, 0, -1);
    reset_mid_flush();
    run_frame(4, 0, 0, 0, -1);
    repeat (24) begin
      run_frame($urandom_range(0, 12), ($urandom_range(0, 3) == 0) ? 1 : 0,
                ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1), -1);
    end
    run_frame(5000, 0, 0, 1, 20);

    repeat (6) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pending_done_a", sb_a.size(), 0);
    chk("pending_done_s", sb_s.size(), 0);
    chk("pending_events", start_q.size() + end_q.size() + ovr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
